// File: rtl/relu_stream_rd.sv
// relu_stream_rd: streams the wide parallel ReLU result bus out one pixel word per beat.
//
// The bus holds KN channels x P = 4*US*US pixels x FW bits. The channels are grouped
// into SEC_NUM = KN/MS sections. Beat k = sec*P + pix carries the MS elements at
// relu_data_i[(k+1)*MS*FW-1 : k*MS*FW]. Beats leave over a valid/ready stream in order.
//
// Optional build macro: RELU_STREAM_RD_ZSKIP_EN
//   When it is defined, an all-zero beat is dropped. Dropping a beat still takes one
//   cycle. The final beat is always presented. When it is undefined, every beat is
//   presented and no zero detect is built.
//
// Ports:
//   clk_i        clock
//   rstn_i       asynchronous active-low reset; aborts a readout with no done_o
//   start_i      one-cycle pulse that begins a readout (ignored while busy)
//   relu_data_i  full ReLU result bus, held stable by upstream until done_o
//   busy_o       high from the cycle after an accepted start_i through the done_o cycle
//   done_o       one-cycle pulse after the final beat handshakes
//   rd_data_o    current pixel word, MS elements of FW bits
//   rd_valid_o   rd_data_o is valid
//   rd_ready_i   downstream accepts the beat
//   rd_sec_o     section index of the current beat
//   rd_pix_o     pixel index within the section of the current beat
//   rd_last_o    current beat is the final one (sec=SEC_NUM-1, pix=P-1)
module relu_stream_rd #(
   parameter  int unsigned FW      = 32,
   parameter  int unsigned US      = 7,
   parameter  int unsigned MS      = 32,
   parameter  int unsigned KN      = 512,
   localparam int unsigned P       = 4 * US * US,
   localparam int unsigned SEC_NUM = KN / MS,
   localparam int unsigned SW      = (SEC_NUM > 1) ? $clog2(SEC_NUM) : 1,
   localparam int unsigned PW      = (P > 1) ? $clog2(P) : 1,
   localparam int unsigned BW      = MS * FW,
   localparam int unsigned DW      = KN * P * FW
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          start_i,
   input  logic [DW-1:0] relu_data_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [BW-1:0] rd_data_o,
   output logic          rd_valid_o,
   input  logic          rd_ready_i,
   output logic [SW-1:0] rd_sec_o,
   output logic [PW-1:0] rd_pix_o,
   output logic          rd_last_o
);

   if (KN % MS != 0) begin : g_bad_cfg
      $error("relu_stream_rd: KN must be a multiple of MS");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SEND  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] sec_q, sec_d;       // section of the next beat to load
   logic [PW-1:0] pix_q, pix_d;       // pixel of the next beat to load
   logic [BW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic [SW-1:0] rsec_q, rsec_d;     // indices of the beat currently presented
   logic [PW-1:0] rpix_q, rpix_d;
   logic          last_q, last_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [31:0]   beat_idx_c;
   logic [BW-1:0] slice_c;
   logic          final_c;
   logic          skip_c;

   // Select the pixel word addressed by the load counters.
   always_comb begin
      beat_idx_c = 32'(sec_q) * 32'(P) + 32'(pix_q);
      slice_c    = relu_data_i[beat_idx_c * BW +: BW];
      final_c    = (sec_q == SW'(SEC_NUM - 1)) && (pix_q == PW'(P - 1));
   end

`ifdef RELU_STREAM_RD_ZSKIP_EN
   // An all-zero beat is dropped, except the final beat. That beat carries rd_last_o.
   always_comb skip_c = (slice_c == '0) && !final_c;
`else
   always_comb skip_c = 1'b0;
`endif

   // Next-state and output-register logic.
   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      pix_d   = pix_q;
      data_d  = data_q;
      valid_d = valid_q;
      rsec_d  = rsec_q;
      rpix_d  = rpix_q;
      last_d  = last_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_SEND;
               sec_d   = '0;
               pix_d   = '0;
            end
         end
         S_SEND: begin
            // The output register is free when it is empty or its beat is taken this cycle.
            if (!valid_q || rd_ready_i) begin
               if (pix_q == PW'(P - 1)) begin
                  pix_d = '0;
                  sec_d = sec_q + SW'(1);
               end else begin
                  pix_d = pix_q + PW'(1);
               end
               if (skip_c) begin
                  valid_d = 1'b0;
               end else begin
                  data_d  = slice_c;
                  valid_d = 1'b1;
                  rsec_d  = sec_q;
                  rpix_d  = pix_q;
                  last_d  = final_c;
                  if (final_c) begin
                     state_d = S_FLUSH;
                  end
               end
            end
         end
         S_FLUSH: begin
            if (rd_ready_i) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
         sec_q   <= '0;
         pix_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         rsec_q  <= '0;
         rpix_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         pix_q   <= pix_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         rsec_q  <= rsec_d;
         rpix_q  <= rpix_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign rd_data_o  = data_q;
   assign rd_valid_o = valid_q;
   assign rd_sec_o   = rsec_q;
   assign rd_pix_o   = rpix_q;
   assign rd_last_o  = last_q;

endmodule

// File: tb/tb_relu_stream_rd.sv
// Bench for relu_stream_rd with a queue scoreboard and forked monitors.
// Instance A: KN=64, MS=32, US=1, FW=32 (2 sections x 4 pixels).
// Instance B: KN=96, MS=32, US=3, FW=8 (3 sections x 36 pixels).
module tb_relu_stream_rd;

   localparam int unsigned A_FW = 32, A_US = 1, A_MS = 32, A_KN = 64;
   localparam int unsigned A_P = 4 * A_US * A_US, A_SEC = A_KN / A_MS, A_NB = A_SEC * A_P;
   localparam int unsigned A_SW = $clog2(A_SEC), A_PW = $clog2(A_P);
   localparam int unsigned B_FW = 8, B_US = 3, B_MS = 32, B_KN = 96;
   localparam int unsigned B_P = 4 * B_US * B_US, B_SEC = B_KN / B_MS, B_NB = B_SEC * B_P;
   localparam int unsigned B_SW = $clog2(B_SEC), B_PW = $clog2(B_P);

   logic clk, rstn;

   logic                        a_start, a_ready, a_busy, a_done, a_valid, a_last;
   logic [A_KN*A_P*A_FW-1:0]    a_bus;
   logic [A_MS*A_FW-1:0]        a_data;
   logic [A_SW-1:0]             a_sec;
   logic [A_PW-1:0]             a_pix;

   logic                        b_start, b_ready, b_busy, b_done, b_valid, b_last;
   logic [B_KN*B_P*B_FW-1:0]    b_bus;
   logic [B_MS*B_FW-1:0]        b_data;
   logic [B_SW-1:0]             b_sec;
   logic [B_PW-1:0]             b_pix;

   relu_stream_rd #(.FW(A_FW), .US(A_US), .MS(A_MS), .KN(A_KN)) u_dut_a (
      .clk_i(clk), .rstn_i(rstn), .start_i(a_start), .relu_data_i(a_bus),
      .busy_o(a_busy), .done_o(a_done), .rd_data_o(a_data), .rd_valid_o(a_valid),
      .rd_ready_i(a_ready), .rd_sec_o(a_sec), .rd_pix_o(a_pix), .rd_last_o(a_last));

   relu_stream_rd #(.FW(B_FW), .US(B_US), .MS(B_MS), .KN(B_KN)) u_dut_b (
      .clk_i(clk), .rstn_i(rstn), .start_i(b_start), .relu_data_i(b_bus),
      .busy_o(b_busy), .done_o(b_done), .rd_data_o(b_data), .rd_valid_o(b_valid),
      .rd_ready_i(b_ready), .rd_sec_o(b_sec), .rd_pix_o(b_pix), .rd_last_o(b_last));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: element values per beat, and the beats expected on the stream.
   int unsigned ea [A_NB][A_MS];
   int unsigned eb [B_NB][B_MS];
   int qa [$];
   int qb [$];

   int errors = 0;
   int checks = 0;
   int a_beats = 0, a_dones = 0, a_first_cyc = -10, a_lasths_cyc = -10;
   int b_beats = 0, b_dones = 0, b_first_cyc = -10, b_lasths_cyc = -10;

   task automatic check(input bit ok, input string name, input string info);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, info);
      end
   endtask

   function automatic bit zero_a(int k);
      for (int m = 0; m < int'(A_MS); m++) if (ea[k][m] != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit zero_b(int k);
      for (int m = 0; m < int'(B_MS); m++) if (eb[k][m] != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic build_a();
      for (int k = 0; k < int'(A_NB); k++)
         for (int m = 0; m < int'(A_MS); m++)
            a_bus[(k*A_MS+m)*A_FW +: A_FW] = A_FW'(ea[k][m]);
   endtask

   task automatic build_b();
      for (int k = 0; k < int'(B_NB); k++)
         for (int m = 0; m < int'(B_MS); m++)
            b_bus[(k*B_MS+m)*B_FW +: B_FW] = B_FW'(eb[k][m]);
   endtask

   // Expected beat order: all beats in order, minus dropped zero beats when zero-skip is built.
   task automatic push_exp_a();
      for (int k = 0; k < int'(A_NB); k++) begin
`ifdef RELU_STREAM_RD_ZSKIP_EN
         if (zero_a(k) && k != int'(A_NB) - 1) continue;
`endif
         qa.push_back(k);
      end
   endtask

   task automatic push_exp_b();
      for (int k = 0; k < int'(B_NB); k++) begin
`ifdef RELU_STREAM_RD_ZSKIP_EN
         if (zero_b(k) && k != int'(B_NB) - 1) continue;
`endif
         qb.push_back(k);
      end
   endtask

   function automatic string diff_a(int k);
      for (int m = 0; m < int'(A_MS); m++)
         if (a_data[m*A_FW +: A_FW] != A_FW'(ea[k][m]))
            return $sformatf("beat %0d elem %0d got %0h want %0h", k, m, a_data[m*A_FW +: A_FW], ea[k][m]);
      return "";
   endfunction

   function automatic string diff_b(int k);
      for (int m = 0; m < int'(B_MS); m++)
         if (b_data[m*B_FW +: B_FW] != B_FW'(eb[k][m]))
            return $sformatf("beat %0d elem %0d got %0h want %0h", k, m, b_data[m*B_FW +: B_FW], eb[k][m]);
      return "";
   endfunction

   task automatic mon_a();
      bit hold = 1'b0;
      logic [A_MS*A_FW-1:0] hd;
      logic [A_SW-1:0] hs;
      logic [A_PW-1:0] hp;
      logic hl;
      int k;
      string d;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            hold = 1'b0;
            continue;
         end
         if (hold)
            check(a_valid && a_data == hd && a_sec == hs && a_pix == hp && a_last == hl, "a_stall_hold",
                  $sformatf("valid=%0b sec=%0d pix=%0d last=%0b, held sec=%0d pix=%0d last=%0b",
                            a_valid, a_sec, a_pix, a_last, hs, hp, hl));
         hold = a_valid && !a_ready;
         hd = a_data; hs = a_sec; hp = a_pix; hl = a_last;
         if (a_valid && a_ready) begin
            if (qa.size() == 0) begin
               check(1'b0, "a_unexpected_beat", $sformatf("got sec=%0d pix=%0d, want no beat", a_sec, a_pix));
            end else begin
               k = qa.pop_front();
               a_beats++;
               check(a_sec == A_SW'(k / int'(A_P)) && a_pix == A_PW'(k % int'(A_P)), "a_beat_index",
                     $sformatf("got sec=%0d pix=%0d want sec=%0d pix=%0d", a_sec, a_pix, k / int'(A_P), k % int'(A_P)));
               check(a_last == (k == int'(A_NB) - 1), "a_last_flag",
                     $sformatf("beat %0d got last=%0b want %0b", k, a_last, k == int'(A_NB) - 1));
               d = diff_a(k);
               check(d.len() == 0, "a_beat_data", d);
               if (k == 0) a_first_cyc = cyc;
               if (k == int'(A_NB) - 1) a_lasths_cyc = cyc;
            end
         end
         if (a_done) begin
            a_dones++;
            check(cyc == a_lasths_cyc + 1, "a_done_timing",
                  $sformatf("done at cycle %0d, want %0d", cyc, a_lasths_cyc + 1));
         end
      end
   endtask

   task automatic mon_b();
      int k;
      string d;
      forever begin
         @(negedge clk);
         if (!rstn) continue;
         if (b_valid && b_ready) begin
            if (qb.size() == 0) begin
               check(1'b0, "b_unexpected_beat", $sformatf("got sec=%0d pix=%0d, want no beat", b_sec, b_pix));
            end else begin
               k = qb.pop_front();
               b_beats++;
               check(b_sec == B_SW'(k / int'(B_P)) && b_pix == B_PW'(k % int'(B_P)) &&
                     b_last == (k == int'(B_NB) - 1), "b_beat_index",
                     $sformatf("got sec=%0d pix=%0d last=%0b want sec=%0d pix=%0d", b_sec, b_pix, b_last,
                               k / int'(B_P), k % int'(B_P)));
               d = diff_b(k);
               check(d.len() == 0, "b_beat_data", d);
               if (k == 0) b_first_cyc = cyc;
               if (k == int'(B_NB) - 1) b_lasths_cyc = cyc;
            end
         end
         if (b_done) begin
            b_dones++;
            check(cyc == b_lasths_cyc + 1, "b_done_timing",
                  $sformatf("done at cycle %0d, want %0d", cyc, b_lasths_cyc + 1));
         end
      end
   endtask

   // mode: 0 ready high, 1 ready toggling, 2 ready random.
   task automatic run_a(input int mode, input int restart_beat, input int abort_beat, input bit chk_lat);
      int s, d0;
      bit seen = 1'b0, rs = 1'b0;
      push_exp_a();
      a_beats = 0;
      d0 = a_dones;
      @(posedge clk); #1;
      a_start = 1'b1;
      a_ready = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      @(negedge clk);
      s = cyc;
      check(a_busy && !a_valid, "a_busy_after_start", $sformatf("busy=%0b valid=%0b, want 1 0", a_busy, a_valid));
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         a_start = 1'b0;
         case (mode)
            0: a_ready = 1'b1;
            1: a_ready = !a_ready;
            default: a_ready = 1'($urandom_range(0, 1));
         endcase
         if (restart_beat >= 0 && !rs && a_beats >= restart_beat) begin
            a_start = 1'b1;
            rs = 1'b1;
         end
         if (abort_beat >= 0 && a_beats >= abort_beat) begin
            rstn = 1'b0;
            #1;
            check(!a_valid && !a_busy && !a_done, "a_abort_outputs",
                  $sformatf("valid=%0b busy=%0b done=%0b, want 0 0 0", a_valid, a_busy, a_done));
            qa.delete();
            @(posedge clk);
            @(posedge clk); #1;
            rstn = 1'b1;
            repeat (4) @(negedge clk);
            check(a_dones == d0 && !a_busy && !a_valid, "a_no_done_after_abort",
                  $sformatf("dones=%0d busy=%0b valid=%0b, want %0d 0 0", a_dones, a_busy, a_valid, d0));
            return;
         end
         @(negedge clk);
         if (a_done) begin
            seen = 1'b1;
            break;
         end
      end
      check(seen, "a_done_seen", "done_o=0 within the cycle budget, want 1");
      check(a_busy, "a_busy_in_done", $sformatf("busy=%0b in done cycle, want 1", a_busy));
      @(negedge clk);
      check(!a_busy && !a_done && !a_valid, "a_idle_after_done",
            $sformatf("busy=%0b done=%0b valid=%0b, want 0 0 0", a_busy, a_done, a_valid));
      check(qa.size() == 0 && a_dones == d0 + 1, "a_beat_count",
            $sformatf("missing beats=%0d dones=%0d, want 0 and %0d", qa.size(), a_dones - d0, 1));
      qa.delete();
      if (chk_lat)
         check(a_first_cyc == s + 1 && a_lasths_cyc == s + int'(A_NB), "a_latency",
               $sformatf("first beat at +%0d last at +%0d, want +1 and +%0d", a_first_cyc - s, a_lasths_cyc - s, A_NB));
   endtask

   task automatic run_b(input int mode, input bit chk_lat);
      int s, d0;
      bit seen = 1'b0;
      push_exp_b();
      b_beats = 0;
      d0 = b_dones;
      @(posedge clk); #1;
      b_start = 1'b1;
      b_ready = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      @(negedge clk);
      s = cyc;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk); #1;
         b_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (b_done) begin
            seen = 1'b1;
            break;
         end
      end
      check(seen, "b_done_seen", "done_o=0 within the cycle budget, want 1");
      @(negedge clk);
      check(qb.size() == 0 && b_dones == d0 + 1 && !b_busy, "b_beat_count",
            $sformatf("missing beats=%0d dones=%0d busy=%0b, want 0 1 0", qb.size(), b_dones - d0, b_busy));
      qb.delete();
      if (chk_lat)
         check(b_first_cyc == s + 1 && b_lasths_cyc == s + int'(B_NB), "b_latency",
               $sformatf("first beat at +%0d last at +%0d, want +1 and +%0d", b_first_cyc - s, b_lasths_cyc - s, B_NB));
   endtask

   initial begin
      rstn    = 1'b1;
      a_start = 1'b0; a_ready = 1'b0; a_bus = '0;
      b_start = 1'b0; b_ready = 1'b0; b_bus = '0;
      #3 rstn = 1'b0;
      fork
         mon_a();
         mon_b();
      join_none
      repeat (3) @(negedge clk);
      check(!a_busy && !a_done && !a_valid && !a_last && a_data == '0 && a_sec == '0 && a_pix == '0,
            "a_reset_state", $sformatf("busy=%0b done=%0b valid=%0b last=%0b sec=%0d pix=%0d, want all 0",
                                       a_busy, a_done, a_valid, a_last, a_sec, a_pix));
      check(!b_busy && !b_done && !b_valid && !b_last && b_data == '0, "b_reset_state",
            $sformatf("busy=%0b done=%0b valid=%0b last=%0b, want all 0", b_busy, b_done, b_valid, b_last));
      @(posedge clk); #1;
      rstn = 1'b1;

      // Ramp data: every element of beat k is k+1.
      for (int k = 0; k < int'(A_NB); k++)
         for (int m = 0; m < int'(A_MS); m++) ea[k][m] = k + 1;
      build_a();
      run_a(0, -1, -1, 1'b1);
      run_a(1, -1, -1, 1'b0);
      run_a(0, 3, -1, 1'b0);
      run_a(0, -1, 4, 1'b0);
      run_a(0, -1, -1, 1'b1);

      // Beats 1, 2 and the final beat 7 all zero.
      for (int m = 0; m < int'(A_MS); m++) begin
         ea[1][m] = 0;
         ea[2][m] = 0;
         ea[7][m] = 0;
      end
      build_a();
      run_a(0, -1, -1, 1'b1);

      // Random data with random zero beats and random backpressure.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < int'(A_NB); k++) begin
            bit z = ($urandom_range(0, 2) == 0);
            for (int m = 0; m < int'(A_MS); m++) ea[k][m] = z ? 0 : $urandom;
         end
         build_a();
         run_a(2, -1, -1, 1'b0);
      end

      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < int'(B_NB); k++) begin
            bit z = ($urandom_range(0, 3) == 0) || (r == 1 && k == int'(B_NB) - 1);
            for (int m = 0; m < int'(B_MS); m++) eb[k][m] = z ? 0 : $urandom_range(0, 255);
         end
         build_b();
         run_b((r == 0) ? 0 : 1, r == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
